// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: data width, bubble encoding, reset PC
// and the IF/DE pipeline payload.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_de_t;

endpackage

// File: rtl/if_de_reg.sv
// IF/DE pipeline register. Flush injects a bubble and beats enable;
// a flushed entry keeps its PC side-band so decode never sees X.
module if_de_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INST
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  input  logic   i_flush,
  input  if_de_t i_d,
  output if_de_t o_q
);

  if_de_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q.inst  <= NOP;
      r_q.pc    <= '0;
      r_q.pc4   <= '0;
      r_q.valid <= 1'b0;
    end else if (i_flush) begin
      r_q.inst  <= NOP;
      r_q.valid <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem addressing, IF/DE register, redirect with
// one-bubble penalty, sticky misaligned-target flag and fetch counter.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP      = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_if,
  input  logic            NextPCSrc,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst_de,
  output logic [XLEN-1:0] pc_de,
  output logic [XLEN-1:0] pc4_de,
  output logic            valid_de,
  output logic            misaligned,
  output logic [XLEN-1:0] fetch_cnt
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fetch_cnt;
  logic            r_misaligned;
  logic [XLEN-1:0] w_pc4;
  logic            w_advance;
  if_de_t          w_ifde_d;
  if_de_t          w_ifde_q;

  assign w_pc4     = r_pc + 32'd4;
  assign w_advance = ~NextPCSrc & ~stall_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_fetch_cnt  <= '0;
      r_misaligned <= 1'b0;
    end else if (NextPCSrc) begin
      // Low bits are dropped so fetch stays word aligned; the flag records it.
      r_pc <= {br_target[XLEN-1:2], 2'b00};
      if (br_target[1:0] != 2'b00) r_misaligned <= 1'b1;
    end else if (w_advance) begin
      r_pc        <= w_pc4;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign w_ifde_d.inst  = imem_rdata;
  assign w_ifde_d.pc    = r_pc;
  assign w_ifde_d.pc4   = w_pc4;
  assign w_ifde_d.valid = 1'b1;

  if_de_reg #(.NOP(NOP)) u_if_de_reg (
    .clk     (clk),
    .rst     (rst),
    .i_en    (~stall_if),
    .i_flush (NextPCSrc),
    .i_d     (w_ifde_d),
    .o_q     (w_ifde_q)
  );

  assign imem_addr  = r_pc;
  assign inst_de    = w_ifde_q.inst;
  assign pc_de      = w_ifde_q.pc;
  assign pc4_de     = w_ifde_q.pc4;
  assign valid_de   = w_ifde_q.valid;
  assign misaligned = r_misaligned;
  assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural fetch model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        NextPCSrc;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_de;
  logic [31:0] pc_de;
  logic [31:0] pc4_de;
  logic        valid_de;
  logic        misaligned;
  logic [31:0] fetch_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model of architectural state
  logic [31:0] m_pc, m_inst, m_pcde, m_pc4de, m_cnt;
  logic        m_valid, m_mis;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall_if   (stall_if),
    .NextPCSrc  (NextPCSrc),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_de    (inst_de),
    .pc_de      (pc_de),
    .pc4_de     (pc4_de),
    .valid_de   (valid_de),
    .misaligned (misaligned),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0050_0093;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_inst = 32'h13; m_pcde = 0; m_pc4de = 0;
    m_valid = 0; m_mis = 0; m_cnt = 0;
  endtask

  // One clock edge with the given controls; model follows the priority rules.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall_if = s; NextPCSrc = r; br_target = t;
    @(posedge clk);
    if (rst) m_reset();
    else if (r) begin
      m_pc    = t & 32'hFFFF_FFFC;
      m_inst  = 32'h13;
      m_valid = 0;
      if (t % 4 != 0) m_mis = 1;
    end else if (!s) begin
      m_inst  = mem_word(m_pc);
      m_pcde  = m_pc;
      m_pc4de = m_pc + 4;
      m_pc    = m_pc + 4;
      m_valid = 1;
      m_cnt   = m_cnt + 1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    cmp("imem_addr",  imem_addr,  m_pc);
    cmp("inst_de",    inst_de,    m_inst);
    cmp("pc_de",      pc_de,      m_pcde);
    cmp("pc4_de",     pc4_de,     m_pc4de);
    cmp("valid_de",   {31'd0, valid_de},   {31'd0, m_valid});
    cmp("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    cmp("fetch_cnt",  fetch_cnt,  m_cnt);
  end

  initial begin
    rst = 1; stall_if = 0; NextPCSrc = 0; br_target = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_addr",  imem_addr, 32'h0);
    cmp("rst_inst",  inst_de,   32'h13);
    cmp("rst_valid", {31'd0, valid_de}, 32'd0);
    cmp("rst_cnt",   fetch_cnt, 32'd0);
    rst = 0;

    step(0, 0, 0);
    cmp("first_inst", inst_de,   32'h0050_0093);
    cmp("first_pc",   pc_de,     32'h0);
    cmp("first_pc4",  pc4_de,    32'h4);
    cmp("first_addr", imem_addr, 32'h4);
    for (int i = 1; i < 5; i++) begin
      step(0, 0, 0);
      cmp("seq_pc", pc_de, 32'(i * 4));
      cmp("seq_valid", {31'd0, valid_de}, 32'd1);
    end
    cmp("seq_cnt", fetch_cnt, 32'd5);

    step(1, 0, 0);
    step(1, 0, 0);
    cmp("stall_addr", imem_addr, 32'd20);
    cmp("stall_pc",   pc_de,     32'd16);
    cmp("stall_cnt",  fetch_cnt, 32'd5);
    step(0, 0, 0);
    cmp("resume_pc",  pc_de,     32'd20);

    step(1, 1, 32'h40);
    cmp("redir_addr",  imem_addr, 32'h40);
    cmp("redir_inst",  inst_de,   32'h13);
    cmp("redir_valid", {31'd0, valid_de}, 32'd0);
    cmp("redir_pchold", pc_de, 32'd20);
    step(0, 0, 0);
    cmp("tgt_pc",    pc_de, 32'h40);
    cmp("tgt_valid", {31'd0, valid_de}, 32'd1);
    cmp("tgt_cnt",   fetch_cnt, 32'd7);

    step(0, 1, 32'h42);
    cmp("mis_addr", imem_addr, 32'h40);
    cmp("mis_flag", {31'd0, misaligned}, 32'd1);
    step(0, 1, 32'h100);
    step(0, 0, 0);
    cmp("mis_sticky", {31'd0, misaligned}, 32'd1);
    cmp("b2b_pc",     pc_de, 32'h100);

    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    cmp("wrap_pc",   pc_de,     32'hFFFF_FFFC);
    cmp("wrap_pc4",  pc4_de,    32'h0);
    cmp("wrap_addr", imem_addr, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic s, r;
      logic [31:0] t;
      s = ($urandom_range(3) == 0);
      r = ($urandom_range(6) == 0);
      t = $urandom;
      if (i < 300) t[1:0] = 2'b00;
      step(s, r, t);
    end

    #2 rst = 1;
    m_reset();
    #1;
    cmp("arst_addr",  imem_addr, 32'h0);
    cmp("arst_inst",  inst_de,   32'h13);
    cmp("arst_pc",    pc_de,     32'h0);
    cmp("arst_valid", {31'd0, valid_de},   32'd0);
    cmp("arst_mis",   {31'd0, misaligned}, 32'd0);
    cmp("arst_cnt",   fetch_cnt, 32'd0);
    step(0, 0, 0);
    rst = 0;
    step(0, 0, 0);
    cmp("post_inst", inst_de, 32'h0050_0093);
    cmp("post_pc4",  pc4_de,  32'h4);
    step(0, 0, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
